syn_fifo: RTL and testbench
===========================

// Module: syn_fifo
// PURPOSE
//  Single-clock FIFO, parametrised successor to the dual-clock FIFO, for buffering inside one clock domain.
//  Adds a fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow
//  flags, synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  WIDTH_FIFO  8                  data width in bits
//  ADDR_FIFO   3                  address width; must be >=1
//  DEPTH_FIFO  1<<ADDR_FIFO       entry count; fixed at this value, not overridable independently
//  FWFT        0                  0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk       in   1             single clock; all logic on the rising edge
//  rst       in   1             synchronous, active-high reset
//  flush     in   1             synchronous clear of pointers and count; memory contents unchanged
//  wen       in   1             write request
//  wdata     in   WIDTH_FIFO    write data
//  ren       in   1             read request (FWFT: pop/acknowledge of the word on rdata)
//  af_th     in   ADDR_FIFO+1   almost-full threshold (0..DEPTH_FIFO)
//  ae_th     in   ADDR_FIFO+1   almost-empty threshold (0..DEPTH_FIFO)
//  clr_err   in   1             clears overflow/underflow
//  rdata     out  WIDTH_FIFO    read data
//  rvalid    out  1             rdata is valid
//  count     out  ADDR_FIFO+1   words stored, 0..DEPTH_FIFO
//  empty     out  1             count==0
//  full      out  1             count==DEPTH_FIFO
//  almost_full   out 1          count >= af_th
//  almost_empty  out 1          count <= ae_th
//  overflow  out  1             sticky: a write was attempted while full
//  underflow out  1             sticky: a read was attempted while empty
// BEHAVIOUR
//  - Pointers wptr/rptr are ADDR_FIFO+1 bits wide. Memory is indexed by [ADDR_FIFO-1:0]; each pointer wraps modulo 2*DEPTH_FIFO.
//  - Accepted write: wa = wen & ~full. Accepted read: ra = ren & ~empty. Both use the flags as registered before the edge.
//  - When full, a write is rejected even if a read is accepted in the same cycle.
//  - When empty, a read is rejected even if a write is accepted in the same cycle (no pass-through).
//  - Count update is registered: count += wa - ra, so wa&ra leaves count unchanged.
//  - empty, full, almost_* are combinational from the registered count, so they reflect an access on the next cycle.
//  - Standard mode (FWFT=0): on ra, rdata <= mem[rptr] at that edge; rvalid=1 for exactly the following cycle.
//    rdata holds its value when there is no accepted read.
//  - FWFT mode (FWFT=1): rdata = mem[rptr] combinational; rvalid = ~empty; ren pops the head word.
//    A word written to an empty FIFO appears on rdata one cycle after the write edge.
//  - overflow sets on wen&full; underflow sets on ren&empty.
//    Both hold until clr_err or rst; if clr_err and a new error coincide, the set wins.
//  - Rejected accesses change no pointer, count or memory.
//  - flush (no rst): wptr=rptr=count=0 and standard-mode rvalid=0 at the edge. wen/ren that cycle are ignored and raise no error.
//    rdata and sticky flags are unaffected.
//  - rst has priority over everything. After the edge: pointers=0, count=0, rdata=0, rvalid=0, overflow=underflow=0,
//    empty=1, full=0, almost_empty=1, almost_full=(af_th==0).
//  - rst asserted mid-stream discards all stored data; the first read after reset returns the first post-reset write.
//  - af_th/ae_th may change at any time; the comparisons are unsigned and take effect combinationally.
// TESTING (WIDTH_FIFO=8, ADDR_FIFO=3)
//  1 Reset, then 8 writes 0x01..0x08 -> full=1 and count=8 after the 8th edge.
//    9th write 0xFF -> overflow=1, count stays 8. Read back -> 0x01..0x08 in order (FWFT=0: each one cycle after ren).
//  2 Hold count=8, assert wen&ren together -> read accepted, write rejected, count=7, overflow=1.
//    At count=0, wen&ren together -> write accepted, underflow=1, count=1.
//  3 Stream 20 writes with interleaved reads (pointer wrap >2x) -> data order preserved, count never exceeds 8.
//  4 af_th=6, ae_th=2: fill 0->8 -> almost_empty=1 for count 0..2, almost_full=1 for count 6..8.
//    Set af_th=0 at count=0 -> almost_full=1.
//  5 Hold count=5, assert flush together with wen -> next cycle count=0, empty=1, no overflow.
//    Write 0xA5 and read it -> 0xA5 returned.
//  6 FWFT=1: write 0x3C into empty FIFO -> next cycle rvalid=1, rdata=0x3C without ren.
//    ren -> rvalid=0 next cycle. Assert rst mid-stream at count=4 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/syn_fifo.sv
// syn_fifo: single-clock FIFO with fill count, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow flags, synchronous flush
// and a selectable standard (registered) or first-word-fall-through read port.
//
// Pointers carry one extra wrap bit beyond the memory index. Because of that
// bit, the pointer difference is the exact occupancy (0..DEPTH_FIFO), so the
// fill count comes straight from the two pointer registers and cannot drift
// from them.
module syn_fifo #(
    parameter  int WIDTH_FIFO = 8,
    parameter  int ADDR_FIFO  = 3,
    parameter  int FWFT       = 0,
    localparam int DEPTH_FIFO = 1 << ADDR_FIFO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wen,
    input  logic [WIDTH_FIFO-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_FIFO:0]    af_th,
    input  logic [ADDR_FIFO:0]    ae_th,
    input  logic                  clr_err,
    output logic [WIDTH_FIFO-1:0] rdata,
    output logic                  rvalid,
    output logic [ADDR_FIFO:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_FIFO:0] DEPTH_CNT = (ADDR_FIFO + 1)'(DEPTH_FIFO);
    localparam logic [ADDR_FIFO:0] PTR_ONE   = (ADDR_FIFO + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH_FIFO-1:0] mem_q [DEPTH_FIFO];

    logic [ADDR_FIFO:0] wptr_q, wptr_d;
    logic [ADDR_FIFO:0] rptr_q, rptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    // Access qualification, all based on the flags registered before the edge.
    logic wr_acc;   // write accepted by the full check
    logic rd_acc;   // read accepted by the empty check
    logic wr_fire;  // write actually performed this edge
    logic rd_fire;  // read actually performed this edge

    // ------------------------------------------------------------------
    // Status flags, derived only from registered pointers
    // ------------------------------------------------------------------
    assign count        = wptr_q - rptr_q;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (count >= af_th);
    assign almost_empty = (count <= ae_th);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO refuses the write even when a read is accepted in the same
    // cycle, and an empty FIFO refuses the read even when a write is accepted:
    // there is no pass-through path. Flush suppresses both.
    assign wr_acc  = wen & ~full;
    assign rd_acc  = ren & ~empty;
    assign wr_fire = wr_acc & ~flush & ~rst;
    assign rd_fire = rd_acc & ~flush & ~rst;

    // Next-state for pointers and sticky error flags.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rptr_d = rptr_q + PTR_ONE;
        end

        // Clear first, then let a coinciding new error win. Accesses ignored
        // because of flush never raise an error.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wen && full && !flush) begin
            overflow_d = 1'b1;
        end
        if (ren && empty && !flush) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and error-flag registers; reset beats flush beats normal update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever assigned with non-blocking <=,
        // so every register samples pre-edge values regardless of block order.
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; empty/rvalid guard every
        // stale entry, and leaving it unreset lets it map onto plain RAM.
        if (wr_fire) begin
            mem_q[wptr_q[ADDR_FIFO-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; rdata is forced to zero
            // while nothing valid is stored so reset and empty show a clean bus.
            assign rvalid = ~empty;
            assign rdata  = empty ? '0 : mem_q[rptr_q[ADDR_FIFO-1:0]];
        end else begin : g_std
            logic [WIDTH_FIFO-1:0] rdata_q;
            logic                  rvalid_q;

            // Registered read: data captured on an accepted read, valid for
            // exactly the following cycle; data held otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_fire;
                    if (rd_fire) begin
                        rdata_q <= mem_q[rptr_q[ADDR_FIFO-1:0]];
                    end
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_syn_fifo.sv
// tb_syn_fifo: drives one standard-mode and one FWFT-mode syn_fifo with the
// same stimulus and compares both against a queue-based reference model.
module tb_syn_fifo;

    localparam int W = 8;
    localparam int A = 3;
    localparam int D = 1 << A;

    logic         clk = 1'b0;
    logic         rst, flush, wen, ren, clr_err;
    logic [W-1:0] wdata;
    logic [A:0]   af_th, ae_th;

    logic [W-1:0] rdata_s, rdata_f;
    logic         rvalid_s, rvalid_f;
    logic [A:0]   count_s, count_f;
    logic         empty_s, empty_f, full_s, full_f;
    logic         af_s, af_f, ae_s, ae_f;
    logic         ovf_s, ovf_f, unf_s, unf_f;

    syn_fifo #(.WIDTH_FIFO(W), .ADDR_FIFO(A), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err),
        .rdata(rdata_s), .rvalid(rvalid_s), .count(count_s), .empty(empty_s), .full(full_s),
        .almost_full(af_s), .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s)
    );

    syn_fifo #(.WIDTH_FIFO(W), .ADDR_FIFO(A), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err),
        .rdata(rdata_f), .rvalid(rvalid_f), .count(count_f), .empty(empty_f), .full(full_f),
        .almost_full(af_f), .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored words as a queue, plus sticky flags and the
    // registered standard-mode read output.
    byte unsigned q[$];
    bit           m_ovf, m_unf, m_rvalid;
    logic [W-1:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_status();
        int n;
        n = q.size();
        return {4'(n), n == 0, n == D, n >= int'(af_th), n <= int'(ae_th), m_ovf, m_unf};
    endfunction

    task automatic model_update(input bit r, input bit fl, input bit we, input logic [W-1:0] wd,
                                input bit re, input bit ce);
        bit was_full, was_empty;
        if (r) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;
        end else if (fl) begin
            q.delete();
            m_rvalid = 0;
            if (ce) begin m_ovf = 0; m_unf = 0; end
        end else begin
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            m_rvalid  = re && !was_empty;
            if (m_rvalid) m_rdata = q.pop_front();
            if (we && !was_full) q.push_back(wd);
            if (ce) begin m_ovf = 0; m_unf = 0; end
            if (we && was_full)  m_ovf = 1;
            if (re && was_empty) m_unf = 1;
        end
    endtask

    task automatic compare_all();
        check("status_std",  {count_s, empty_s, full_s, af_s, ae_s, ovf_s, unf_s}, exp_status());
        check("status_fwft", {count_f, empty_f, full_f, af_f, ae_f, ovf_f, unf_f}, exp_status());
        check("rvalid_std",  rvalid_s, m_rvalid);
        check("rdata_std",   rdata_s,  m_rdata);
        check("rvalid_fwft", rvalid_f, q.size() != 0);
        check("rdata_fwft",  rdata_f,  (q.size() != 0) ? q[0] : 8'h00);
    endtask

    // One clock cycle: drive, let the edge happen, advance model, compare.
    task automatic cyc(input bit r, input bit fl, input bit we, input logic [W-1:0] wd,
                       input bit re, input bit ce);
        rst = r; flush = fl; wen = we; wdata = wd; ren = re; clr_err = ce;
        @(posedge clk);
        model_update(r, fl, we, wd, re, ce);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int g = 0; g < 2 * D && q.size() != 0; g++) cyc(0, 0, 0, 8'h00, 1, 0);
        check("drain_empty", empty_s, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; flush = 0; wen = 0; ren = 0; clr_err = 0; wdata = '0;
        af_th = 4'd8; ae_th = 4'd0;

        // 1: reset, fill, overflow, ordered read-back
        cyc(1, 0, 0, 8'h00, 0, 0);
        check("rst_empty", empty_s, 1'b1);
        check("rst_rdata", rdata_s, 8'h00);
        for (int i = 1; i <= D; i++) cyc(0, 0, 1, 8'(i), 0, 0);
        check("t1_full", full_s, 1'b1);
        check("t1_count", count_s, 4'd8);
        cyc(0, 0, 1, 8'hFF, 0, 0);
        check("t1_ovf", ovf_s, 1'b1);
        check("t1_count9", count_s, 4'd8);
        for (int i = 1; i <= D; i++) begin
            cyc(0, 0, 0, 8'h00, 1, 0);
            check("t1_rdata", rdata_s, 8'(i));
            check("t1_rvalid", rvalid_s, 1'b1);
        end
        cyc(0, 0, 0, 8'h00, 0, 0);
        check("t1_rvalid_drop", rvalid_s, 1'b0);

        // 2: simultaneous access at full and at empty
        cyc(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < D; i++) cyc(0, 0, 1, 8'(8'h10 + i), 0, 0);
        cyc(0, 0, 1, 8'hEE, 1, 0);
        check("t2_count7", count_s, 4'd7);
        check("t2_ovf", ovf_s, 1'b1);
        check("t2_rd_head", rdata_s, 8'h10);
        drain();
        cyc(0, 0, 1, 8'h77, 1, 0);
        check("t2_unf", unf_s, 1'b1);
        check("t2_count1", count_s, 4'd1);
        cyc(0, 0, 0, 8'h00, 1, 0);
        check("t2_rd77", rdata_s, 8'h77);

        // 3: interleaved stream with multiple pointer wraps
        cyc(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(8'h40 + i), (i % 3) != 0, 0);
        drain();

        // 4: thresholds
        af_th = 4'd6; ae_th = 4'd2;
        for (int i = 0; i <= D; i++) begin
            check("t4_ae", ae_s, i <= 2);
            check("t4_af", af_s, i >= 6);
            if (i < D) cyc(0, 0, 1, 8'(8'h80 + i), 0, 0);
        end
        drain();
        af_th = 4'd0;
        #1;
        check("t4_af_th0", af_s, 1'b1);
        af_th = 4'd6;
        #1;

        // 5: flush with concurrent write, including while full
        cyc(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'hC0 + i), 0, 0);
        cyc(0, 1, 1, 8'h99, 0, 0);
        check("t5_count0", count_s, 4'd0);
        check("t5_empty", empty_s, 1'b1);
        check("t5_no_ovf", ovf_s, 1'b0);
        cyc(0, 0, 1, 8'hA5, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 0);
        check("t5_rdA5", rdata_s, 8'hA5);
        for (int i = 0; i < D; i++) cyc(0, 0, 1, 8'(i), 0, 0);
        cyc(0, 1, 1, 8'h55, 0, 0);
        check("t5_flush_full_ovf", ovf_s, 1'b0);
        cyc(0, 1, 0, 8'h00, 1, 0);
        check("t5_flush_empty_unf", unf_s, 1'b0);

        // 6: FWFT behaviour and mid-stream reset
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, 8'h3C, 0, 0);
        check("t6_fwft_rvalid", rvalid_f, 1'b1);
        check("t6_fwft_rdata", rdata_f, 8'h3C);
        cyc(0, 0, 0, 8'h00, 1, 0);
        check("t6_fwft_pop", rvalid_f, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(8'hD0 + i), 0, 0);
        cyc(0, 0, 1, 8'hFE, 1, 1);
        cyc(1, 0, 1, 8'hEE, 1, 0);
        check("t6_rst_all",
              {count_s, count_f, empty_s, empty_f, full_s, full_f, ae_s, ae_f,
               af_s, af_f, ovf_s, ovf_f, unf_s, unf_f, rvalid_s, rvalid_f},
              {8'h00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        check("t6_rst_rdata", {rdata_s, rdata_f}, 16'h0000);
        cyc(0, 0, 1, 8'h61, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 0);
        check("t6_first_after_rst", rdata_s, 8'h61);

        // Randomised traffic with bias phases, flushes, resets and threshold changes
        for (int c = 0; c < 1500; c++) begin
            int  wp, rp;
            bit  r, fl, ce;
            wp = ((c / 100) % 2 == 0) ? 65 : 35;
            rp = 100 - wp;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 49) == 0);
            ce = !fl && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) af_th = 4'($urandom_range(0, D));
            if ($urandom_range(0, 29) == 0) ae_th = 4'($urandom_range(0, D));
            cyc(r, fl, $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp, ce);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
